// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state/grant encodings and wait-counter width for mem_port_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {GNT_CPU = 1'b0, GNT_LD = 1'b1} gnt_t;
    localparam int CNT_W = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU, loader and memory-side signals of the shared memory port
// slave  = arbiter view (requests in, responses and memory strobes out, mem_rdata in)
// master = requester/memory view (the mirror image)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req, cpu_we, cpu_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              ld_req, ld_we, ld_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata, ld_rdata;
    logic              mem_en, mem_we, grant_ld;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, ld_rdata, ld_ack, mem_en, mem_we, mem_addr, mem_wdata, grant_ld
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, ld_rdata, ld_ack, mem_en, mem_we, mem_addr, mem_wdata, grant_ld
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker
// req[0]=CPU, req[1]=loader; on a tie the side not granted last wins; valid = any request
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       last_grant,
    output gnt_t       grant,
    output logic       valid
);
    assign valid = |req;
    assign grant = (req == 2'b11) ? ((last_grant == GNT_LD) ? GNT_CPU : GNT_LD)
                                  : (req[1] ? GNT_LD : GNT_CPU);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU and a loader with wait states
// clk, reset (async, active-low); bus: CPU/loader request-response and memory port signals
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    gnt_t              gnt_q, gnt_d, last_q, last_d, pick;
    logic              pick_v, we_q, we_d, last_cyc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, crd_q, crd_d, lrd_q, lrd_d;
    rr_pick2 u_pick (
        .req        ({bus.ld_req, bus.cpu_req}),
        .last_grant (last_q),
        .grant      (pick),
        .valid      (pick_v)
    );
    assign last_cyc = (state_q == ACCESS) && (cnt_q == '0);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        crd_d   = crd_q;
        lrd_d   = lrd_q;
        if (state_q == IDLE) begin
            if (pick_v) begin
                state_d = ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                gnt_d   = pick;
                we_d    = (pick == GNT_LD) ? bus.ld_we    : bus.cpu_we;
                addr_d  = (pick == GNT_LD) ? bus.ld_addr  : bus.cpu_addr;
                wdata_d = (pick == GNT_LD) ? bus.ld_wdata : bus.cpu_wdata;
            end
        end else if (state_q == ACCESS) begin
            cnt_d = last_cyc ? '0 : cnt_q - 1'b1;
            if (last_cyc) begin
                state_d = RESP;
                crd_d   = (gnt_q == GNT_CPU) ? bus.mem_rdata : crd_q;
                lrd_d   = (gnt_q == GNT_LD)  ? bus.mem_rdata : lrd_q;
            end
        end else begin
            state_d = IDLE;
            last_d  = gnt_q;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= GNT_CPU;
            last_q  <= GNT_LD;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            crd_q   <= '0;
            lrd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            crd_q   <= crd_d;
            lrd_q   <= lrd_d;
        end
    end
    // The write strobe is only raised on the final access cycle so each write commits once.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = last_cyc & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = crd_q;
    assign bus.ld_rdata  = lrd_q;
    assign bus.cpu_ready = (state_q == RESP) && (gnt_q == GNT_CPU);
    assign bus.ld_ack    = (state_q == RESP) && (gnt_q == GNT_LD);
    assign bus.grant_ld  = (gnt_q == GNT_LD);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a behavioural model
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
    logic [31:0] mem_a [256] = '{default: '0};
    logic [31:0] mem_b [256] = '{default: '0};
    logic [31:0] model_b [256] = '{default: '0};
    int wr_a = 0;
    int cp_b = 0;
    int lp_b = 0;
    assign bus_a.mem_rdata = (bus_a.mem_addr == 32'h10) ? 32'hDEAD_BEEF : mem_a[bus_a.mem_addr[9:2]];
    assign bus_b.mem_rdata = mem_b[bus_b.mem_addr[9:2]];
    always @(posedge clk) begin
        if (bus_a.mem_en && bus_a.mem_we) begin
            mem_a[bus_a.mem_addr[9:2]] <= bus_a.mem_wdata;
            wr_a <= wr_a + 1;
        end
        if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr[9:2]] <= bus_b.mem_wdata;
        if (bus_b.cpu_ready) cp_b <= cp_b + 1;
        if (bus_b.ld_ack) lp_b <= lp_b + 1;
    end
    task automatic idle_inputs;
        {bus_a.cpu_req, bus_a.cpu_we, bus_a.ld_req, bus_a.ld_we} = '0;
        {bus_b.cpu_req, bus_b.cpu_we, bus_b.ld_req, bus_b.ld_we} = '0;
        {bus_a.cpu_addr, bus_a.cpu_wdata, bus_a.ld_addr, bus_a.ld_wdata} = '0;
        {bus_b.cpu_addr, bus_b.cpu_wdata, bus_b.ld_addr, bus_b.ld_wdata} = '0;
    endtask
    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus_a.mem_en, bus_a.mem_we, bus_a.cpu_ready, bus_a.ld_ack, bus_a.grant_ld} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus_a.mem_en, bus_a.mem_we, bus_a.cpu_ready, bus_a.ld_ack, bus_a.grant_ld});
        end
        n_checks++;
        if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.cpu_rdata, bus_a.ld_rdata} !== 128'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h want 0", bus_a.mem_addr, bus_a.mem_wdata, bus_a.cpu_rdata, bus_a.ld_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask
    task automatic cpu_read_a(input string tag);
        int en_n, we_n, rdy_n, rdy_at;
        en_n = 0; we_n = 0; rdy_n = 0; rdy_at = -1;
        bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 32'h10;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            en_n += int'(bus_a.mem_en);
            we_n += int'(bus_a.mem_we);
            if (bus_a.cpu_ready) begin
                rdy_n++; rdy_at = i; bus_a.cpu_req = 1'b0;
            end
        end
        bus_a.cpu_req = 1'b0;
        n_checks++;
        if (en_n != 2) begin n_fail++; $display("FAIL %s mem_en_cycles: got %0d want 2", tag, en_n); end
        n_checks++;
        if (we_n != 0) begin n_fail++; $display("FAIL %s mem_we_cycles: got %0d want 0", tag, we_n); end
        n_checks++;
        if (rdy_n != 1 || rdy_at != 3) begin n_fail++; $display("FAIL %s ready: got %0d pulses at %0d want 1 at 3", tag, rdy_n, rdy_at); end
        n_checks++;
        if (bus_a.cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL %s rdata: got %h want deadbeef", tag, bus_a.cpu_rdata); end
    endtask
    task automatic test_cpu_read;
        cpu_read_a("cpu_read");
    endtask
    task automatic test_ld_write;
        int we_n, we_at, ack_n, ack_at, w0;
        logic [31:0] wa, wd;
        we_n = 0; we_at = -1; ack_n = 0; ack_at = -1; w0 = wr_a; wa = '0; wd = '0;
        bus_a.ld_req = 1'b1; bus_a.ld_we = 1'b1; bus_a.ld_addr = 32'h40; bus_a.ld_wdata = 32'h1234_5678;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus_a.mem_we) begin we_n++; we_at = i; wa = bus_a.mem_addr; wd = bus_a.mem_wdata; end
            if (bus_a.ld_ack) begin ack_n++; ack_at = i; bus_a.ld_req = 1'b0; end
        end
        bus_a.ld_req = 1'b0; bus_a.ld_we = 1'b0;
        n_checks++;
        if (we_n != 1 || we_at != 2) begin n_fail++; $display("FAIL ld_write_we: got %0d at %0d want 1 at 2", we_n, we_at); end
        n_checks++;
        if (wa !== 32'h40 || wd !== 32'h1234_5678) begin n_fail++; $display("FAIL ld_write_bus: got %h/%h want 00000040/12345678", wa, wd); end
        n_checks++;
        if (ack_n != 1 || ack_at != 3) begin n_fail++; $display("FAIL ld_write_ack: got %0d at %0d want 1 at 3", ack_n, ack_at); end
        n_checks++;
        if (mem_a[16] !== 32'h1234_5678 || wr_a - w0 != 1) begin n_fail++; $display("FAIL ld_write_mem: got %h (%0d writes) want 12345678 (1)", mem_a[16], wr_a - w0); end
    endtask
    task automatic test_back_to_back;
        logic [3:0] ord;
        int np, nc, nl, t_last;
        ord = '0; np = 0; nc = 0; nl = 0; t_last = -1;
        bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 32'h100;
        bus_a.ld_req = 1'b1; bus_a.ld_addr = 32'h200;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            nc += int'(bus_a.cpu_ready);
            nl += int'(bus_a.ld_ack);
            if (bus_a.cpu_ready || bus_a.ld_ack) begin
                ord = {ord[2:0], bus_a.ld_ack};
                np++; t_last = i;
                n_checks++;
                if (bus_a.grant_ld !== bus_a.ld_ack) begin n_fail++; $display("FAIL dual_grant_ld: got %b want %b", bus_a.grant_ld, bus_a.ld_ack); end
                if (np == 4) begin bus_a.cpu_req = 1'b0; bus_a.ld_req = 1'b0; end
            end
        end
        n_checks++;
        if (ord !== 4'b0101 || np != 4) begin n_fail++; $display("FAIL dual_order: got %b (%0d) want 0101 (4)", ord, np); end
        n_checks++;
        if (nc != 2 || nl != 2) begin n_fail++; $display("FAIL dual_counts: got cpu %0d ld %0d want 2 2", nc, nl); end
        n_checks++;
        if (t_last != 15) begin n_fail++; $display("FAIL dual_throughput: last pulse at %0d want 15", t_last); end
    endtask
    task automatic test_drop;
        int en_n, rdy_n;
        en_n = 0; rdy_n = 0;
        bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 32'h10;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) bus_a.cpu_req = 1'b0;
            en_n += int'(bus_a.mem_en);
            rdy_n += int'(bus_a.cpu_ready);
        end
        n_checks++;
        if (rdy_n != 1) begin n_fail++; $display("FAIL drop_ready: got %0d pulses want 1", rdy_n); end
        n_checks++;
        if (en_n != 2) begin n_fail++; $display("FAIL drop_single_txn: got %0d access cycles want 2", en_n); end
    endtask
    task automatic test_reset_mid_write;
        int t, w0, pulses;
        w0 = wr_a; t = 0; pulses = 0;
        bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b1; bus_a.cpu_addr = 32'h80; bus_a.cpu_wdata = 32'hA5A5_A5A5;
        do begin @(negedge clk); t++; end while (!bus_a.mem_we && t < 10);
        n_checks++;
        if (t != 2) begin n_fail++; $display("FAIL rst_mid_reach: mem_we at %0d want 2", t); end
        reset = 1'b0;
        bus_a.cpu_req = 1'b0; bus_a.cpu_we = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.mem_en, bus_a.mem_we, bus_a.cpu_ready, bus_a.ld_ack, bus_a.grant_ld} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: got %b want 00000", {bus_a.mem_en, bus_a.mem_we, bus_a.cpu_ready, bus_a.ld_ack, bus_a.grant_ld});
        end
        n_checks++;
        if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.cpu_rdata, bus_a.ld_rdata} !== 128'b0) begin
            n_fail++;
            $display("FAIL rst_mid_data: got %h %h %h %h want 0", bus_a.mem_addr, bus_a.mem_wdata, bus_a.cpu_rdata, bus_a.ld_rdata);
        end
        repeat (2) begin @(negedge clk); pulses += int'(bus_a.cpu_ready); end
        reset = 1'b1;
        repeat (2) begin @(negedge clk); pulses += int'(bus_a.cpu_ready); end
        n_checks++;
        if (wr_a != w0 || mem_a[32] !== 32'h0 || pulses != 0) begin
            n_fail++;
            $display("FAIL rst_mid_nowrite: got %0d writes, mem %h, %0d pulses want 0, 0, 0", wr_a - w0, mem_a[32], pulses);
        end
        cpu_read_a("rst_recover");
    endtask
    task automatic side(input int s);
        logic        we_r;
        logic [7:0]  w;
        logic [31:0] d, got;
        int          t;
        for (int n = 0; n < 50; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we_r = 1'($urandom_range(0, 1));
            w = 8'(s * 32) + 8'($urandom_range(0, 31));
            d = $urandom;
            if (s == 0) begin
                bus_b.cpu_req = 1'b1; bus_b.cpu_we = we_r; bus_b.cpu_addr = {22'b0, w, 2'b00}; bus_b.cpu_wdata = d;
            end else begin
                bus_b.ld_req = 1'b1; bus_b.ld_we = we_r; bus_b.ld_addr = {22'b0, w, 2'b00}; bus_b.ld_wdata = d;
            end
            t = 0;
            do begin @(negedge clk); t++; end while (!(s == 0 ? bus_b.cpu_ready : bus_b.ld_ack) && t < 20);
            if (s == 0) bus_b.cpu_req = 1'b0; else bus_b.ld_req = 1'b0;
            got = (s == 0) ? bus_b.cpu_rdata : bus_b.ld_rdata;
            n_checks++;
            if (t >= 20) begin
                n_fail++; $display("FAIL sweep_timeout side %0d txn %0d: no pulse in %0d cycles", s, n, t);
            end else if (!we_r && got !== model_b[w]) begin
                n_fail++; $display("FAIL sweep_rdata side %0d word %0d: got %h want %h", s, w, got, model_b[w]);
            end
            if (we_r) model_b[w] = d;
        end
    endtask
    task automatic test_random_sweep;
        int c0, l0, bad;
        c0 = cp_b; l0 = lp_b; bad = 0;
        fork
            side(0);
            side(1);
        join
        repeat (3) @(negedge clk);
        n_checks++;
        if (cp_b - c0 != 50 || lp_b - l0 != 50) begin n_fail++; $display("FAIL sweep_pulses: got cpu %0d ld %0d want 50 50", cp_b - c0, lp_b - l0); end
        for (int i = 0; i < 64; i++) bad += int'(mem_b[i] !== model_b[i]);
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL sweep_mem: got %0d mismatching words want 0", bad); end
    endtask
    initial begin
        test_reset();
        test_cpu_read();
        test_ld_write();
        test_back_to_back();
        test_drop();
        test_reset_mid_write();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
